// File: rtl/mem_pkg.sv
// Shared types and constants for the line-memory controller and its backing RAM.
package mem_pkg;

    localparam int unsigned LINE_W   = 256;
    localparam int unsigned OFFSET_W = 5;
    localparam int unsigned CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } mem_state_t;

endpackage

// File: rtl/line_ram.sv
// Single-port DEPTH x LINE_W synchronous array with a registered read port that holds between reads.
module line_ram
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 512
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [$clog2(DEPTH)-1:0]   idx_i,
    input  logic                       we_i,
    input  logic                       re_i,
    input  logic [LINE_W-1:0]          wdata_i,
    output logic [LINE_W-1:0]          rdata_o
);

    logic [LINE_W-1:0] mem_q [DEPTH];
    logic [LINE_W-1:0] rd_data_q;
    logic [LINE_W-1:0] rd_data_d;

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (re_i) begin
            rd_data_d = mem_q[idx_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rdata_o = rd_data_q;

endmodule

// File: rtl/line_memory_ctrl.sv
// Fixed-latency 256-bit line memory behind the data cache: one request at a time, one-cycle ack.
module line_memory_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY = 10,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                mem_enable_i,
    input  logic                mem_write_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [LINE_W-1:0]   mem_data_i,
    output logic                mem_ack_o,
    output logic [LINE_W-1:0]   mem_data_o
);

    localparam int unsigned    IDX_W  = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              wr_q, wr_d;
    logic [LINE_W-1:0] data_q, data_d;

    logic ram_we;
    logic ram_re;

    // Offset and upper address bits are intentionally dropped (line wrap modulo DEPTH).
    logic addr_unused;
    assign addr_unused = &{1'b0, mem_addr_i[OFFSET_W-1:0], mem_addr_i[ADDR_W-1:OFFSET_W+IDX_W]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        data_d  = data_q;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_enable_i) begin
                    idx_d   = mem_addr_i[OFFSET_W +: IDX_W];
                    wr_d    = mem_write_i;
                    data_d  = mem_data_i;
                    cnt_d   = LAT_M1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Commit edge; a reset on this edge must suppress the write.
                if (cnt_q == '0) begin
                    ram_we  = wr_q & ~rst_i;
                    ram_re  = ~wr_q & ~rst_i;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
        end
    end

    line_ram #(
        .DEPTH (DEPTH)
    ) u_line_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .idx_i   (idx_q),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .wdata_i (data_q),
        .rdata_o (mem_data_o)
    );

    assign mem_ack_o = (state_q == ACK);

endmodule

// File: tb/tb_line_memory_ctrl.sv
// Directed self-checking bench for line_memory_ctrl.
module tb_line_memory_ctrl;

    localparam int unsigned LAT   = 10;
    localparam int unsigned DEPTH = 512;

    logic         clk;
    logic         rst;
    logic         en;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic         ack;
    logic [255:0] rdata;

    int total;
    int bad;
    int cyc;

    localparam logic [255:0] PAT_A = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] PAT_W = {8{32'h1234_5678}};
    localparam logic [255:0] PAT_X = {8{32'hA5A5_0001}};
    localparam logic [255:0] PAT_Y = {8{32'h5A5A_0002}};
    localparam logic [255:0] PAT_C = {8{32'hC0C0_C0C0}};
    localparam logic [255:0] PAT_D = {8{32'h0BAD_0BAD}};

    line_memory_ctrl #(
        .LATENCY (LAT),
        .DEPTH   (DEPTH),
        .ADDR_W  (32)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .mem_enable_i (en),
        .mem_write_i  (wr),
        .mem_addr_i   (addr),
        .mem_data_i   (wdata),
        .mem_ack_o    (ack),
        .mem_data_o   (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Issues one request (caller sits #1 after an edge) and returns edges from acceptance to ack, or -1.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [255:0] d, output int lat);
        en    = 1'b1;
        wr    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        en    = 1'b0;
        wr    = 1'b0;
        wdata = '0;
        lat   = -1;
        for (int i = 1; i <= int'(LAT) + 20; i++) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (ack !== 1'b0) begin
                bad++;
                $display("FAIL reset_ack cycle %0d: got %b want 0", i, ack);
            end
            total++;
            if (rdata !== '0) begin
                bad++;
                $display("FAIL reset_data cycle %0d: got %h want 0", i, rdata);
            end
        end
    endtask

    task automatic test_write_read();
        int lat;
        do_req(1'b1, 32'h0000_0040, PAT_A, lat);
        total++;
        if (lat !== int'(LAT)) begin
            bad++;
            $display("FAIL wr_latency: got %0d want %0d", lat, LAT);
        end
        total++;
        if (rdata !== '0) begin
            bad++;
            $display("FAIL wr_keeps_rdata: got %h want 0", rdata);
        end
        @(posedge clk);
        #1;
        total++;
        if (ack !== 1'b0) begin
            bad++;
            $display("FAIL ack_one_cycle: got %b want 0", ack);
        end
        do_req(1'b0, 32'h0000_0040, '0, lat);
        total++;
        if (lat !== int'(LAT)) begin
            bad++;
            $display("FAIL rd_latency: got %0d want %0d", lat, LAT);
        end
        total++;
        if (rdata !== PAT_A) begin
            bad++;
            $display("FAIL rd_data_0x40: got %h want %h", rdata, PAT_A);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_offset();
        int lat;
        do_req(1'b0, 32'h0000_005F, '0, lat);
        total++;
        if (lat !== int'(LAT)) begin
            bad++;
            $display("FAIL offset_latency: got %0d want %0d", lat, LAT);
        end
        total++;
        if (rdata !== PAT_A) begin
            bad++;
            $display("FAIL offset_data: got %h want %h", rdata, PAT_A);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        int lat;
        do_req(1'b1, 32'h0000_4000, PAT_W, lat);
        total++;
        if (lat !== int'(LAT)) begin
            bad++;
            $display("FAIL wrap_wr_latency: got %0d want %0d", lat, LAT);
        end
        total++;
        if (rdata !== PAT_A) begin
            bad++;
            $display("FAIL wrap_wr_holds_rdata: got %h want %h", rdata, PAT_A);
        end
        @(posedge clk);
        #1;
        do_req(1'b0, 32'h0000_0000, '0, lat);
        total++;
        if (rdata !== PAT_W) begin
            bad++;
            $display("FAIL wrap_rd_data: got %h want %h", rdata, PAT_W);
        end
        @(posedge clk);
        #1;
    endtask

    // Enable held high: ACK -> IDLE -> accept, so consecutive acks are LAT+2 edges apart.
    task automatic test_back_to_back();
        int lat;
        int last_ack;
        int n_ack;
        logic [255:0] exp_d;
        do_req(1'b1, 32'h0000_0100, PAT_X, lat);
        @(posedge clk);
        #1;
        do_req(1'b1, 32'h0000_0120, PAT_Y, lat);
        @(posedge clk);
        #1;
        en = 1'b1;
        wr = 1'b0;
        addr = 32'h0000_0100;
        last_ack = -1;
        n_ack = 0;
        for (int i = 0; i < 4 * (int'(LAT) + 2) + 10 && n_ack < 4; i++) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) begin
                exp_d = (n_ack % 2 == 0) ? PAT_X : PAT_Y;
                total++;
                if (rdata !== exp_d) begin
                    bad++;
                    $display("FAIL b2b_data ack %0d: got %h want %h", n_ack, rdata, exp_d);
                end
                if (last_ack >= 0) begin
                    total++;
                    if (cyc - last_ack !== int'(LAT) + 2) begin
                        bad++;
                        $display("FAIL b2b_spacing ack %0d: got %0d want %0d", n_ack, cyc - last_ack, LAT + 2);
                    end
                end
                last_ack = cyc;
                n_ack++;
                addr = (n_ack % 2 == 0) ? 32'h0000_0100 : 32'h0000_0120;
                if (n_ack == 4) en = 1'b0;
            end
        end
        total++;
        if (n_ack !== 4) begin
            bad++;
            $display("FAIL b2b_ack_count: got %0d want 4", n_ack);
        end
        en = 1'b0;
        n_ack = 0;
        for (int i = 0; i < 2 * int'(LAT); i++) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) n_ack++;
        end
        total++;
        if (n_ack !== 0) begin
            bad++;
            $display("FAIL b2b_extra_ack: got %0d want 0", n_ack);
        end
    endtask

    task automatic test_abort();
        int lat;
        int n_ack;
        do_req(1'b1, 32'h0000_0080, PAT_C, lat);
        @(posedge clk);
        #1;
        en = 1'b1; wr = 1'b1; addr = 32'h0000_0080; wdata = PAT_D;
        @(posedge clk);
        #1;
        en = 1'b0; wr = 1'b0; wdata = '0;
        repeat (LAT / 2 - 1) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_ack = 0;
        for (int i = 0; i < 2 * int'(LAT); i++) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) n_ack++;
        end
        total++;
        if (n_ack !== 0) begin
            bad++;
            $display("FAIL abort_no_ack: got %0d want 0", n_ack);
        end
        total++;
        if (rdata !== '0) begin
            bad++;
            $display("FAIL abort_rdata_reset: got %h want 0", rdata);
        end
        do_req(1'b0, 32'h0000_0080, '0, lat);
        total++;
        if (lat !== int'(LAT)) begin
            bad++;
            $display("FAIL abort_rd_latency: got %0d want %0d", lat, LAT);
        end
        total++;
        if (rdata !== PAT_C) begin
            bad++;
            $display("FAIL abort_rd_data: got %h want %h", rdata, PAT_C);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_vs_enable();
        int n_ack;
        en = 1'b1; wr = 1'b1; addr = 32'h0000_0040; wdata = PAT_D;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        en = 1'b0; wr = 1'b0; wdata = '0;
        n_ack = 0;
        for (int i = 0; i < int'(LAT) + 5; i++) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) n_ack++;
        end
        total++;
        if (n_ack !== 0) begin
            bad++;
            $display("FAIL rst_en_dropped: got %0d acks want 0", n_ack);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        test_reset();
        test_write_read();
        test_offset();
        test_wrap();
        test_back_to_back();
        test_abort();
        test_reset_vs_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
